alu_req_arbiter: RTL
====================

Name: alu_req_arbiter

Overview:
- Shares the single integer ALU between NREQ requesters, e.g. the execute stage and the branch/address unit.
- Each requester presents a valid/ready request carrying ALUOp, funct ({funct7[5], funct3}) and two operands.
- The block picks one request per cycle using round-robin, registers it onto the ALU-side port, and tracks the issuing requester through the ALU latency.
- The result is returned to the requester that issued it. A flush input cancels all in-flight work.

Parameters:
- NREQ, 2, number of requesters (2..4).
- XLEN, 32, operand and result width.
- LAT, 1, cycles from alu_issue high to alu_result valid (1..4).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  cancels in-flight and same-cycle requests.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept, one-hot or zero.
- req_aluop  in  3*NREQ  ALUOp per requester; slice i is [3i+2:3i].
- req_funct  in  4*NREQ  {funct7[5], funct3} per requester.
- req_a  in  XLEN*NREQ  operand A per requester.
- req_b  in  XLEN*NREQ  operand B per requester.
- alu_issue  out  1  registered; ALU-side fields are valid.
- alu_aluop  out  3  registered ALUOp to the ALU control decoder.
- alu_funct  out  4  registered funct to the ALU control decoder.
- alu_a  out  XLEN  registered operand A.
- alu_b  out  XLEN  registered operand B.
- alu_result  in  XLEN  ALU result, valid LAT cycles after alu_issue.
- rsp_valid  out  NREQ  one-hot response strobe, one cycle, no backpressure.
- rsp_data  out  XLEN  response data, valid while any rsp_valid bit is high.

Behaviour:
- Reset (rst=1 at a rising edge):
  - rr_ptr=0; alu_issue=0; alu_aluop/funct/a/b=0.
  - Tag pipeline cleared; rsp_valid=0; rsp_data=0.
  - req_ready=0 while rst is high.
- Arbitration (combinational):
  - The winner is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready = one-hot of the winner; all zeros when no request is valid, or when flush or rst is high.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- Accept = req_valid[i] & req_ready[i]. At most one accept per cycle, giving a throughput of one op per cycle.
- On an accept at cycle T:
  - At T+1: alu_issue=1 and alu_* hold the winner's fields.
  - rr_ptr becomes (winner+1) mod NREQ at T+1.
- With no accept, alu_issue=0 at T+1, alu_* hold their previous values, and rr_ptr is unchanged.
- Tag pipeline:
  - LAT stages of {valid, requester index}. Stage 0 loads on alu_issue; the entry shifts each cycle.
  - When the final stage is valid, rsp_valid[idx]=1 and rsp_data=alu_result, both registered.
  - Total latency from accept to rsp_valid is LAT+2 cycles (LAT=1 gives a response at T+3).
- Back-to-back accepts from different requesters return in order, one per cycle. No reordering.
- flush=1 at an edge:
  - Clears alu_issue and all tag-pipeline valids.
  - Suppresses rsp_valid on the next cycle. rsp_data may hold stale data.
  - No accept occurs in a flush cycle. rr_ptr is unchanged.
- flush and rst high together behave as rst.
- Reset mid-operation drops all in-flight work; no response is ever produced for it.
- A request held with req_valid=1 and not ready must keep its fields stable. The arbiter samples fields only on accept.
- Fairness: with every requester continuously valid, grants rotate 0,1,..,NREQ-1,0,...; no requester waits more than NREQ-1 accept cycles.
- Widths:
  - rr_ptr is clog2(NREQ) bits and wraps modulo NREQ, including for NREQ=3.
  - When NREQ=1, rr_ptr is constant 0.

Optional Feature:
- ALU_ARB_FIXED_PRIO_EN.
- Defined: the winner is the lowest-index valid requester; rr_ptr is not implemented. Requester 0 may starve the others.
- Undefined: round-robin as specified above.
- All other timing is identical in both builds.

Test Plan:
- Reset then idle: rst high for 2 cycles, then all req_valid=0 for 10 cycles -> req_ready=0, alu_issue=0 and rsp_valid=0 throughout.
- Single op (LAT=1): req0 {aluop=000, funct=1000, a=10, b=3} at T.
  - -> req_ready=01 at T; alu_issue=1 with alu_a=10, alu_b=3 at T+1.
  - Model ALU returns 7 -> rsp_valid=01 and rsp_data=7 at T+3.
- Round-robin contention: req0 and req1 continuously valid for 6 cycles.
  - -> grant sequence 0,1,0,1,0,1.
  - Responses come back in the same order, one per cycle, each carrying its own operands' result.
- Flush in flight (LAT=2): accept req1 at T, flush=1 at T+2 -> no rsp_valid at T+3 or T+4; a new req0 accepted at T+3 responds at T+7.
- Flush vs request: req0 valid with flush=1 in the same cycle -> req_ready=00, no issue; the request is accepted on the next cycle once flush=0.
- NREQ=3 wrap: req0, req1 and req2 all valid, repeated -> grants 0,1,2,0; rr_ptr wraps from 2 to 0.
  - Under ALU_ARB_FIXED_PRIO_EN -> grants 0,0,0,0.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one integer ALU between NREQ requesters; tags each
// issued op with its requester and steers the result back. Define ALU_ARB_FIXED_PRIO_EN for fixed priority.
module alu_req_arbiter #(
  parameter int NREQ = 2,
  parameter int XLEN = 32,
  parameter int LAT  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [3*NREQ-1:0]    req_aluop,
  input  logic [4*NREQ-1:0]    req_funct,
  input  logic [XLEN*NREQ-1:0] req_a,
  input  logic [XLEN*NREQ-1:0] req_b,
  output logic                 alu_issue,
  output logic [2:0]           alu_aluop,
  output logic [3:0]           alu_funct,
  output logic [XLEN-1:0]      alu_a,
  output logic [XLEN-1:0]      alu_b,
  input  logic [XLEN-1:0]      alu_result,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [XLEN-1:0]      rsp_data
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: a request transfers when req_valid[i] & req_ready[i] at a rising edge.
  // req_ready is a function of req_valid (one-hot winner); requesters must not
  // make req_valid depend on req_ready, and hold fields stable until accepted.
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   win_idx;
  logic            found;
  logic            accept;
  logic [IW-1:0]   issue_idx;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [IW-1:0]   rr_ptr;
  int              j;

  always_comb begin
    grant   = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req_valid[j]) begin
        found   = 1'b1;
        win_idx = IW'(j);
      end
    end
    if (found && !flush && !rst) grant[win_idx] = 1'b1;
  end

  if (NREQ == 1) begin : g_ptr_const
    assign rr_ptr = '0;
  end else begin : g_ptr
    always_ff @(posedge clk) begin
      if (rst) rr_ptr <= '0;
      else if (accept) rr_ptr <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end
`else
  always_comb begin
    grant   = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[k]) begin
        found   = 1'b1;
        win_idx = IW'(k);
      end
    end
    if (found && !flush && !rst) grant[win_idx] = 1'b1;
  end
`endif

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);

  // ALU-side register: fields are sampled only on accept and otherwise held.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_issue <= 1'b0;
      alu_aluop <= '0;
      alu_funct <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      issue_idx <= '0;
    end else begin
      alu_issue <= accept;
      if (accept) begin
        alu_aluop <= req_aluop[int'(win_idx)*3 +: 3];
        alu_funct <= req_funct[int'(win_idx)*4 +: 4];
        alu_a     <= req_a[int'(win_idx)*XLEN +: XLEN];
        alu_b     <= req_b[int'(win_idx)*XLEN +: XLEN];
        issue_idx <= win_idx;
      end
    end
  end

  // Tag pipeline mirrors the ALU latency so the final stage lines up with alu_result.
  logic [LAT-1:0]         tag_v;
  logic [LAT-1:0][IW-1:0] tag_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v   <= '0;
      tag_idx <= '0;
    end else begin
      if (flush) tag_v <= '0;
      else begin
        tag_v[0] <= alu_issue;
        for (int s = 1; s < LAT; s++) tag_v[s] <= tag_v[s-1];
      end
      tag_idx[0] <= issue_idx;
      for (int s = 1; s < LAT; s++) tag_idx[s] <= tag_idx[s-1];
    end
  end

  logic [NREQ-1:0] rsp_onehot;

  always_comb begin
    rsp_onehot = '0;
    rsp_onehot[tag_idx[LAT-1]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else if (flush) begin
      rsp_valid <= '0;
    end else begin
      rsp_valid <= tag_v[LAT-1] ? rsp_onehot : '0;
      if (tag_v[LAT-1]) rsp_data <= alu_result;
    end
  end

endmodule
